cordic_phase_gen: RTL and testbench

- Upstream angle source for the 12-iteration CORDIC rotator.
- A phase accumulator (NCO) steps phase in degrees and wraps at 360°.
- Each phase is folded into the rotator's convergence range, ±90°, and presented as a signed 20-bit Q8.12 angle.
- A "negate" flag is delay-matched to the rotator pipeline so the downstream consumer can restore the true sign of cos/sin.

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_flag_delay.sv | 30 +++
 rtl/cordic_phase_gen.sv | 84 ++++++++
 tb/tb_cordic_phase_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared widths, Q8.12 degree constants and the phase fold used by the CORDIC front end.
package cordic_pkg;

  localparam int unsigned ANGLE_W = 20;
  localparam int unsigned PHASE_W = 21;
  localparam int unsigned FRAC_W  = 12;
  localparam int unsigned ATAN_W  = ANGLE_W;

  localparam logic [PHASE_W-1:0] D90  = PHASE_W'(368640);
  localparam logic [PHASE_W-1:0] D180 = PHASE_W'(737280);
  localparam logic [PHASE_W-1:0] D270 = PHASE_W'(1105920);
  localparam logic [PHASE_W-1:0] D360 = PHASE_W'(1474560);

  typedef struct packed {
    logic                      neg;
    logic signed [ANGLE_W-1:0] angle;
  } fold_t;

  // Fold a phase in [0, 360) into [-90, +90]; neg marks a 180-degree rotation.
  function automatic fold_t fold_phase(input logic [PHASE_W-1:0] p);
    fold_t r;
    r.neg   = 1'b0;
    r.angle = ANGLE_W'(p);
    if (p <= D90) begin
      r.angle = ANGLE_W'(p);
    end else if (p < D270) begin
      r.angle = ANGLE_W'(p - D180);
      r.neg   = 1'b1;
    end else begin
      r.angle = ANGLE_W'(p - D360);
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_flag_delay.sv
// Fixed-depth shift register that carries side-band flags alongside the rotator pipeline.
module cordic_flag_delay #(
  parameter int unsigned DEPTH = 14,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [DEPTH];

  // Shift every cycle; reset flushes every stage so in-flight flags are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// Degree-domain NCO feeding the CORDIC rotator with folded angles and a delay-matched negate flag.
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int unsigned LATENCY = 14,
  parameter int unsigned PW      = 21
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ANGLE_W-1:0]        freq_word,
  input  logic                      phase_load,
  input  logic [PW-1:0]             phase_init,
  output logic signed [ANGLE_W-1:0] angle,
  output logic                      angle_valid,
  output logic [PW-1:0]             phase,
  output logic                      negate_aligned,
  output logic                      valid_aligned
);

  // One extra bit so acc + freq_word never overflows before the wrap compare.
  localparam int unsigned SW = PW + 1;
  localparam logic [SW-1:0] D360_S = SW'(D360);

  logic [PW-1:0]             acc_q, acc_d;
  logic signed [ANGLE_W-1:0] angle_q, angle_d;
  logic                      valid_q, valid_d;
  logic                      neg_q, neg_d;
  logic [SW-1:0]             sum_c;
  logic [SW-1:0]             init_c;
  fold_t                     fold_c;
  logic [1:0]                aligned_c;

  // Next-state: load beats enable; idle keeps phase, angle and negate.
  always_comb begin
    acc_d   = acc_q;
    angle_d = angle_q;
    valid_d = 1'b0;
    neg_d   = neg_q;
    sum_c   = SW'(acc_q) + SW'(freq_word);
    init_c  = SW'(phase_init);
    fold_c  = fold_phase(PHASE_W'(acc_q));
    if (phase_load) begin
      acc_d = (init_c >= D360_S) ? PW'(init_c - D360_S) : phase_init;
    end else if (enable) begin
      angle_d = fold_c.angle;
      neg_d   = fold_c.neg;
      valid_d = 1'b1;
      acc_d   = (sum_c >= D360_S) ? PW'(sum_c - D360_S) : PW'(sum_c);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
      neg_q   <= neg_d;
    end
  end

  cordic_flag_delay #(
    .DEPTH (LATENCY),
    .W     (2)
  ) u_flag_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({neg_q, valid_q}),
    .q     (aligned_c)
  );

  assign angle          = angle_q;
  assign angle_valid    = valid_q;
  assign phase          = acc_q;
  assign negate_aligned = aligned_c[1];
  assign valid_aligned  = aligned_c[0];

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Scoreboard bench for cordic_phase_gen: degree-domain reference model, decoupled monitor.
module tb_cordic_phase_gen;

  localparam int LAT  = 14;
  localparam int D90  = 368640;
  localparam int D180 = 737280;
  localparam int D270 = 1105920;
  localparam int D360 = 1474560;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [19:0]        freq_word = '0;
  logic               phase_load = 1'b0;
  logic [20:0]        phase_init = '0;
  logic signed [19:0] angle;
  logic               angle_valid;
  logic [20:0]        phase;
  logic               negate_aligned;
  logic               valid_aligned;

  cordic_phase_gen #(.LATENCY(LAT), .PW(21)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .freq_word      (freq_word),
    .phase_load     (phase_load),
    .phase_init     (phase_init),
    .angle          (angle),
    .angle_valid    (angle_valid),
    .phase          (phase),
    .negate_aligned (negate_aligned),
    .valid_aligned  (valid_aligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit neg;
    int due;
  } al_t;

  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  m_acc = 0;
  int  exp_phase = 0;
  int  exp_angle = 0;
  bit  exp_av = 1'b0;
  bit  mon_en = 1'b0;
  int  ang_q[$];
  al_t al_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: phase is degrees*4096 taken modulo 360 degrees; fold by quadrant.
  task automatic model_edge(input bit r, input bit e, input bit l, input int init, input int fw);
    int a;
    bit n;
    cyc++;
    if (r) begin
      m_acc = 0; exp_av = 0; exp_angle = 0;
      ang_q.delete(); al_q.delete();
    end else if (l) begin
      m_acc = init % D360; exp_av = 0;
    end else if (e) begin
      if (m_acc <= D90)      begin a = m_acc;        n = 0; end
      else if (m_acc < D270) begin a = m_acc - D180; n = 1; end
      else                   begin a = m_acc - D360; n = 0; end
      ang_q.push_back(a);
      al_q.push_back('{neg: n, due: cyc + LAT});
      exp_angle = a; exp_av = 1;
      m_acc = (m_acc + fw) % D360;
    end else begin
      exp_av = 0;
    end
    exp_phase = m_acc;
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int init, input int fw);
    reset = r; enable = e; phase_load = l;
    phase_init = 21'(init); freq_word = 20'(fw);
    @(posedge clk);
    #1 model_edge(r, e, l, init, fw);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares every cycle, pops the scoreboard whenever the DUT presents a sample.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("phase", int'(phase), exp_phase);
      chk("angle_valid", int'(angle_valid), int'(exp_av));
      if (angle_valid) begin
        if (ang_q.size() == 0) chk("angle_unexpected", 1, 0);
        else chk("angle", int'(angle), ang_q.pop_front());
      end else begin
        chk("angle_hold", int'(angle), exp_angle);
      end
      if (valid_aligned) begin
        if (al_q.size() == 0) begin
          chk("valid_aligned_unexpected", 1, 0);
        end else begin
          al_t e;
          e = al_q.pop_front();
          chk("aligned_cycle", cyc, e.due);
          chk("negate_aligned", int'(negate_aligned), int'(e.neg));
        end
      end else if (al_q.size() != 0 && al_q[0].due <= cyc) begin
        al_t e;
        e = al_q.pop_front();
        chk("valid_aligned_missing", cyc, e.due);
      end
    end
  end

  int exp30[8] = '{0, 122880, 245760, 368640, -245760, -122880, 0, 122880};

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom), 1'($urandom), int'($urandom & 32'h1FFFFF), int'($urandom & 32'hFFFFF));
    mon_en = 1'b1;
    chk("rst_angle", int'(angle), 0);
    chk("rst_angle_valid", int'(angle_valid), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_negate_aligned", int'(negate_aligned), 0);
    chk("rst_valid_aligned", int'(valid_aligned), 0);
    for (int i = 0; i < LAT; i++) begin
      step(0, 0, 0, 0, 0);
      chk("post_rst_valid_aligned", int'(valid_aligned), 0);
    end

    // 30-degree steps from reset release.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 122880);
      chk($sformatf("step30_%0d", i), int'(angle), exp30[i]);
    end

    // Wrap through 360 degrees.
    step(0, 0, 1, 1433600, 0);
    step(0, 1, 0, 0, 81920);
    chk("wrap_angle0", int'(angle), -40960);
    chk("wrap_phase", int'(phase), 40960);
    step(0, 1, 0, 0, 81920);
    chk("wrap_angle1", int'(angle), 40960);

    // Exact quadrant boundaries.
    step(0, 0, 1, 368640, 0);  step(0, 1, 0, 0, 0);
    chk("bound_90", int'(angle), 368640);
    step(0, 0, 1, 737280, 0);  step(0, 1, 0, 0, 0);
    chk("bound_180", int'(angle), 0);
    step(0, 0, 1, 1105920, 0); step(0, 1, 0, 0, 0);
    chk("bound_270", int'(angle), -368640);

    // Load of 400 degrees wins over enable.
    step(0, 1, 1, 1638400, 122880);
    chk("load_phase", int'(phase), 163840);
    chk("load_valid", int'(angle_valid), 0);
    step(0, 1, 0, 0, 0);
    chk("load_angle", int'(angle), 163840);
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0, 0, 0);

    // Irregular enable pattern at 120 degrees, aligned flags checked by scoreboard.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 491520); step(0, 0, 0, 0, 491520);
    step(0, 1, 0, 0, 491520); step(0, 1, 0, 0, 491520);
    step(0, 0, 0, 0, 491520);
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0, 0, 0);

    // Mid-stream reset discards in-flight flags.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 491520);
    step(1, 1, 0, 0, 491520);
    for (int i = 0; i < LAT + 2; i++) begin
      step(0, 0, 0, 0, 0);
      chk("flush_valid_aligned", int'(valid_aligned), 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom % 80) == 0, ($urandom % 4) != 0, ($urandom % 12) == 0,
           int'($urandom & 32'h1FFFFF), int'($urandom & 32'hFFFFF));
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0, 0, 0);

    chk("angle_queue_drained", ang_q.size(), 0);
    chk("aligned_queue_drained", al_q.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
